reaction_trial_ctrl: RTL and testbench

Trial sequencer for the reaction-time monitor. On each start press it captures the free-running random value from the clock divider and waits a random delay with the stimulus LED off. It then lights the LED and measures the user's reaction time in milliseconds. It rejects false starts and timeouts, and averages every TRIALS valid results for the averaging-filter display path.

---
 rtl/reaction_trial_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reaction_trial_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_trial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reaction_trial_ctrl
// Brief    : Reaction-time trial sequencer: random pre-stimulus delay, ms
//            reaction measurement, false-start/timeout rejection, averaging.
// Revision : 1.0
// ============================================================================
module reaction_trial_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_W       = 13,
    parameter int TIME_W       = 14,
    parameter int TIMEOUT_MS   = 9999,
    parameter int TRIALS       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              react,
    input  logic [RAND_W-1:0] random,
    output logic              led,
    output logic              busy,
    output logic [TIME_W-1:0] rt_ms,
    output logic              rt_valid,
    output logic [TIME_W-1:0] avg_ms,
    output logic              avg_valid,
    output logic              early,
    output logic              timeout
);

    localparam int c_PRE_W  = $clog2(TICK_DIV);
    localparam int c_LOG2   = $clog2(TRIALS);
    localparam int c_MIN_W  = $clog2(MIN_DELAY_MS + 1);
    // One bit above the wider operand so MIN_DELAY_MS + random never wraps.
    localparam int c_REM_W  = ((RAND_W > c_MIN_W) ? RAND_W : c_MIN_W) + 1;
    localparam int c_SUM_W  = TIME_W + c_LOG2;
    localparam int c_CNT_W  = c_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_ARMED  = 3'd2,
        S_RESULT = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_start_q;
    logic               r_react_q;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_REM_W-1:0] r_remaining;
    logic [TIME_W-1:0]  r_rt_cnt;
    logic [c_SUM_W-1:0] r_sum;
    logic [c_CNT_W-1:0] r_trial_cnt;
    logic               r_avg_pend;

    logic               w_start_edge;
    logic               w_react_edge;
    logic               w_tick;
    logic [c_REM_W-1:0] w_rem_load;
    logic [TIME_W-1:0]  w_rt_next;
    logic               w_timeout_hit;

    assign w_start_edge  = start & ~r_start_q;
    assign w_react_edge  = react & ~r_react_q;
    assign w_tick        = (r_presc == c_PRE_W'(TICK_DIV - 1));
    assign w_rem_load    = c_REM_W'(MIN_DELAY_MS) + c_REM_W'(random);
    assign w_rt_next     = r_rt_cnt + 1'b1;
    assign w_timeout_hit = (w_rt_next == TIME_W'(TIMEOUT_MS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_react_q   <= 1'b0;
            r_presc     <= '0;
            r_remaining <= '0;
            r_rt_cnt    <= '0;
            r_sum       <= '0;
            r_trial_cnt <= '0;
            r_avg_pend  <= 1'b0;
            led         <= 1'b0;
            busy        <= 1'b0;
            rt_ms       <= '0;
            rt_valid    <= 1'b0;
            avg_ms      <= '0;
            avg_valid   <= 1'b0;
            early       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_start_q <= start;
            r_react_q <= react;
            rt_valid  <= 1'b0;
            avg_valid <= 1'b0;
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;

            // Average completes one cycle after the last counted result,
            // independent of whatever the FSM does in that cycle.
            if (r_avg_pend) begin
                avg_ms      <= TIME_W'(r_sum >> c_LOG2);
                avg_valid   <= 1'b1;
                r_sum       <= '0;
                r_trial_cnt <= '0;
                r_avg_pend  <= 1'b0;
            end

            case (r_state)
                S_DELAY: begin
                    if (w_react_edge) begin
                        r_state <= S_FAULT;
                        early   <= 1'b1;
                        busy    <= 1'b0;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        if (r_remaining <= c_REM_W'(1)) begin
                            r_state     <= S_ARMED;
                            r_remaining <= '0;
                            r_rt_cnt    <= '0;
                            led         <= 1'b1;
                            r_presc     <= '0;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (w_react_edge) begin
                        r_state     <= S_RESULT;
                        led         <= 1'b0;
                        busy        <= 1'b0;
                        rt_ms       <= r_rt_cnt;
                        rt_valid    <= 1'b1;
                        r_sum       <= r_sum + c_SUM_W'(r_rt_cnt);
                        r_trial_cnt <= r_trial_cnt + 1'b1;
                        r_avg_pend  <= (r_trial_cnt == c_CNT_W'(TRIALS - 1));
                        r_presc     <= '0;
                    end else if (w_tick) begin
                        if (w_timeout_hit) begin
                            r_state <= S_FAULT;
                            timeout <= 1'b1;
                            led     <= 1'b0;
                            busy    <= 1'b0;
                            r_presc <= '0;
                        end else begin
                            r_rt_cnt <= w_rt_next;
                        end
                    end
                end
                default: begin
                    if (w_start_edge) begin
                        r_state     <= S_DELAY;
                        r_remaining <= w_rem_load;
                        early       <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        r_presc     <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_trial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_trial_ctrl
// Brief    : Directed self-checking bench for reaction_trial_ctrl.
// Revision : 1.0
// ============================================================================
module tb_reaction_trial_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int MIN_DELAY_MS = 2;
    localparam int RAND_W       = 13;
    localparam int TIME_W       = 14;
    localparam int TIMEOUT_MS   = 50;
    localparam int TRIALS       = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              react = 1'b0;
    logic [RAND_W-1:0] random = '0;
    logic              led;
    logic              busy;
    logic [TIME_W-1:0] rt_ms;
    logic              rt_valid;
    logic [TIME_W-1:0] avg_ms;
    logic              avg_valid;
    logic              early;
    logic              timeout;

    int n_checks = 0;
    int n_err    = 0;
    int rtv_cnt  = 0;

    reaction_trial_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .MIN_DELAY_MS(MIN_DELAY_MS),
        .RAND_W      (RAND_W),
        .TIME_W      (TIME_W),
        .TIMEOUT_MS  (TIMEOUT_MS),
        .TRIALS      (TRIALS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .react    (react),
        .random   (random),
        .led      (led),
        .busy     (busy),
        .rt_ms    (rt_ms),
        .rt_valid (rt_valid),
        .avg_ms   (avg_ms),
        .avg_valid(avg_valid),
        .early    (early),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rt_valid) rtv_cnt++;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from DELAY entry until led rises (bounded).
    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 500) begin
            step();
            n++;
        end
    endtask

    task automatic run_trial(input int rnd, input int ms, input int exp_avg);
        int n;
        int v0;
        random = RAND_W'(rnd);
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("busy_on_start", int'(busy), 1);
        check("early_cleared", int'(early), 0);
        check("timeout_cleared", int'(timeout), 0);
        wait_led(n);
        check("led_delay_cycles", n, (MIN_DELAY_MS + rnd) * TICK_DIV);
        repeat (ms * TICK_DIV) step();
        check("led_held", int'(led), 1);
        v0    = rtv_cnt;
        react = 1'b1;
        step();
        check("rt_valid", int'(rt_valid), 1);
        check("rt_ms", int'(rt_ms), ms);
        check("led_off", int'(led), 0);
        step();
        check("rt_valid_pulse", int'(rt_valid), 0);
        if (exp_avg >= 0) begin
            check("avg_valid", int'(avg_valid), 1);
            check("avg_ms", int'(avg_ms), exp_avg);
            check("trial_cnt_clear", int'(dut.r_trial_cnt), 0);
        end else begin
            check("avg_valid_low", int'(avg_valid), 0);
        end
        step();
        react = 1'b0;
        check("avg_valid_pulse", int'(avg_valid), 0);
        check("rt_valid_count", rtv_cnt, v0 + 1);
        step();
    endtask

    initial begin
        int n;
        int v0;
        int ledseen;

        // Reset with both buttons held
        rst = 1'b1; start = 1'b1; react = 1'b1;
        step();
        step();
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rt_ms", int'(rt_ms), 0);
        check("rst_rt_valid", int'(rt_valid), 0);
        check("rst_avg_ms", int'(avg_ms), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_early", int'(early), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_state", int'(dut.r_state), 0);
        rst = 1'b0; start = 1'b0; react = 1'b0;
        step();
        step();
        check("idle_after_rst", int'(busy), 0);

        // Normal trial, random=3 -> led after 20 cycles, 10 ms
        run_trial(3, 10, -1);
        check("trial_cnt_1", int'(dut.r_trial_cnt), 1);

        // False start 5 cycles into DELAY
        random = RAND_W'(4);
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (4) step();
        v0    = rtv_cnt;
        react = 1'b1;
        step();
        react = 1'b0;
        check("early_set", int'(early), 1);
        check("early_busy", int'(busy), 0);
        ledseen = 0;
        repeat (40) begin
            step();
            if (led) ledseen++;
        end
        check("early_no_led", ledseen, 0);
        check("early_no_rt_valid", rtv_cnt, v0);
        check("early_sticky", int'(early), 1);
        check("early_not_counted", int'(dut.r_trial_cnt), 1);

        // Averaging: 10+20+30+41 = 101 -> 25
        run_trial(1, 20, -1);
        check("trial_cnt_2", int'(dut.r_trial_cnt), 2);
        run_trial(0, 30, -1);
        run_trial(2, 41, 25);

        // Timeout at the 50th tick
        random = RAND_W'(0);
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_led(n);
        check("to_led_delay", n, MIN_DELAY_MS * TICK_DIV);
        v0 = rtv_cnt;
        repeat (TIMEOUT_MS * TICK_DIV - 1) step();
        check("to_not_yet", int'(timeout), 0);
        check("to_led_still_on", int'(led), 1);
        step();
        check("to_timeout", int'(timeout), 1);
        check("to_led_off", int'(led), 0);
        check("to_busy_off", int'(busy), 0);
        check("to_no_rt_valid", rtv_cnt, v0);
        check("to_trial_cnt", int'(dut.r_trial_cnt), 0);
        check("to_avg_held", int'(avg_ms), 25);

        // Two counted trials, then reset mid-ARMED
        run_trial(0, 8, -1);
        run_trial(0, 8, -1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_led(n);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_led", int'(led), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rt_ms", int'(rt_ms), 0);
        check("mid_rst_avg_ms", int'(avg_ms), 0);
        check("mid_rst_trial_cnt", int'(dut.r_trial_cnt), 0);
        step();
        run_trial(1, 8, -1);
        run_trial(0, 8, -1);
        run_trial(2, 8, -1);
        run_trial(0, 8, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
